// File: rtl/frame_stream_sequencer.sv
// Frame buffer reader that streams RGB444 frames as Avalon-ST video packets through
// a 2-entry skid buffer, with frame-aligned filter mode latching and restart flush.
module frame_stream_sequencer #(
  parameter int unsigned H_RES  = 320,
  parameter int unsigned V_RES  = 240,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned PIX_W  = 12,
  parameter int unsigned MODE_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              restart,
  input  logic [MODE_W-1:0] mode_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
  output logic              src_eop,
  output logic [MODE_W-1:0] active_mode,
  output logic [15:0]       frame_count
);

  localparam int unsigned COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_RES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_RES - 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  typedef struct packed {
    logic [PIX_W-1:0]  pix;
    logic              sop;
    logic              eop;
    logic [MODE_W-1:0] mode;
  } beat_t;

  state_t            state;
  logic [ADDR_W-1:0] pix_cnt;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;

  beat_t             fifo0, fifo1, nxt0, nxt1, wr_beat;
  logic [1:0]        fifo_cnt, nxt_cnt, cnt_after_pop;

  logic              inflight, infl_sop, infl_eop, infl_zero;
  logic [MODE_W-1:0] infl_mode;

  logic pop, eop_xfer, restart_take, flushing, flush_done;
  logic eop_pending, room, rd_real, rd_zero, issue, at_first, at_last;

  assign rd_addr  = pix_cnt;
  assign src_data = fifo0.pix;
  assign src_sop  = fifo0.sop;
  assign src_eop  = fifo0.eop;

  assign pop          = src_valid & src_ready;
  assign eop_xfer     = pop & fifo0.eop;
  assign restart_take = (state == STREAM) & restart & ~eop_xfer;
  assign flushing     = (state == FLUSH) | restart_take;
  assign flush_done   = (state == FLUSH) & eop_xfer;

  // Row/column wrap detection keeps the last-pixel test free of any multiply.
  assign at_first = (col == '0) & (row == '0);
  assign at_last  = (col == COL_LAST) & (row == ROW_LAST);

  // Once the frame's eop is buffered or in flight, flushing only needs to drain.
  assign eop_pending = (inflight & infl_eop)
                     | ((fifo_cnt != 2'd0) & fifo0.eop)
                     | ((fifo_cnt == 2'd2) & fifo1.eop);

  assign cnt_after_pop = fifo_cnt - {1'b0, pop};
  assign room          = (cnt_after_pop + {1'b0, inflight}) < 2'd2;
  assign rd_real       = (state == STREAM) & ~restart_take & room;
  assign rd_zero       = flushing & ~eop_pending & room;
  assign issue         = rd_real | rd_zero;

  always_comb begin
    wr_beat.pix  = infl_zero ? '0 : rd_data;
    wr_beat.sop  = infl_sop;
    wr_beat.eop  = infl_eop;
    wr_beat.mode = infl_mode;

    nxt0    = fifo0;
    nxt1    = fifo1;
    nxt_cnt = fifo_cnt;
    if (pop) begin
      nxt0    = fifo1;
      nxt_cnt = fifo_cnt - 2'd1;
    end
    if (inflight) begin
      if (nxt_cnt == 2'd0) nxt0 = wr_beat;
      else                 nxt1 = wr_beat;
      nxt_cnt = nxt_cnt + 2'd1;
    end
    // Leaving a flush discards anything queued behind the eop so the next frame restarts at pixel 0.
    if (flush_done) nxt_cnt = 2'd0;
    if (nxt_cnt == 2'd0) begin
      nxt0 = '0;
      nxt1 = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pix_cnt     <= '0;
      col         <= '0;
      row         <= '0;
      fifo0       <= '0;
      fifo1       <= '0;
      fifo_cnt    <= '0;
      src_valid   <= 1'b0;
      inflight    <= 1'b0;
      infl_sop    <= 1'b0;
      infl_eop    <= 1'b0;
      infl_zero   <= 1'b0;
      infl_mode   <= '0;
      active_mode <= '0;
      frame_count <= '0;
    end else begin
      fifo0     <= nxt0;
      fifo1     <= nxt1;
      fifo_cnt  <= nxt_cnt;
      src_valid <= (nxt_cnt != 2'd0);

      inflight  <= issue;
      infl_sop  <= at_first;
      infl_eop  <= at_last;
      infl_zero <= rd_zero;
      infl_mode <= mode_req;

      // The mode captured with pixel 0 takes over exactly when its sop beat reaches the head.
      if ((nxt_cnt != 2'd0) && nxt0.sop) active_mode <= nxt0.mode;

      if (eop_xfer) frame_count <= frame_count + 16'd1;

      if (flush_done) begin
        pix_cnt <= '0;
        col     <= '0;
        row     <= '0;
      end else if (issue) begin
        if (at_last) begin
          pix_cnt <= '0;
          col     <= '0;
          row     <= '0;
        end else begin
          pix_cnt <= pix_cnt + ADDR_W'(1);
          if (col == COL_LAST) begin
            col <= '0;
            row <= row + ROW_W'(1);
          end else begin
            col <= col + COL_W'(1);
          end
        end
      end

      case (state)
        IDLE:    state <= STREAM;
        STREAM:  if (restart_take) state <= FLUSH;
        FLUSH:   if (flush_done) state <= STREAM;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_stream_sequencer.sv
// Randomized self-checking bench for frame_stream_sequencer on a reduced 16x6 frame.
module tb_frame_stream_sequencer;
  localparam int unsigned H  = 16;
  localparam int unsigned V  = 6;
  localparam int unsigned N  = H * V;
  localparam int unsigned AW = 7;
  localparam int unsigned PW = 12;
  localparam int unsigned MW = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          restart = 1'b0;
  logic          src_ready = 1'b0;
  logic [MW-1:0] mode_req = '0;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_data = '0;
  logic [PW-1:0] src_data;
  logic          src_valid, src_sop, src_eop;
  logic [MW-1:0] active_mode;
  logic [15:0]   frame_count;

  logic [PW-1:0] mem [0:(1<<AW)-1];
  int unsigned   n_checks = 0;
  int unsigned   n_pass = 0;

  frame_stream_sequencer #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .PIX_W(PW), .MODE_W(MW)) dut (
    .clk(clk), .reset_n(reset_n), .restart(restart), .mode_req(mode_req),
    .rd_addr(rd_addr), .rd_data(rd_data), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .src_sop(src_sop), .src_eop(src_eop),
    .active_mode(active_mode), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Frame buffer read port: registered q, one cycle after the address.
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic load_mem(input bit ramp);
    for (int i = 0; i < (1 << AW); i++)
      mem[i] = ramp ? PW'(i) : PW'($urandom_range(1, 4095));
  endtask

  task automatic do_reset();
    src_ready = 1'b0;
    restart   = 1'b0;
    reset_n   = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // Applies inputs for one clock and reports the beat accepted at that edge.
  task automatic cycle(input logic rdy, input logic rs, output logic xf,
                       output logic [PW-1:0] d, output logic s, output logic e);
    src_ready = rdy;
    restart   = rs;
    xf = src_valid & rdy;
    d  = src_data;
    s  = src_sop;
    e  = src_eop;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int unsigned lat;
    load_mem(1'b0);
    mode_req = 3'd4;
    #3 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({rd_addr, src_valid, src_sop, src_eop, src_data, active_mode, frame_count} !== '0)
      $display("FAIL reset_outputs got addr=%h v=%b sop=%b eop=%b d=%h mode=%h fc=%h want all zero",
               rd_addr, src_valid, src_sop, src_eop, src_data, active_mode, frame_count);
    else n_pass++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    lat = 0;
    while (src_valid !== 1'b1 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (src_valid !== 1'b1 || lat > 3)
      $display("FAIL first_valid_latency got %0d cycles (valid=%b) want <=3", lat, src_valid);
    else n_pass++;
    n_checks++;
    if ({src_sop, src_eop, src_data} !== {1'b1, 1'b0, mem[0]})
      $display("FAIL first_beat got sop=%b eop=%b d=%h want sop=1 eop=0 d=%h", src_sop, src_eop, src_data, mem[0]);
    else n_pass++;
    n_checks++;
    if (active_mode !== 3'd4) $display("FAIL first_mode got %0d want 4", active_mode);
    else n_pass++;
  endtask

  task automatic test_steady();
    logic xf, s, e;
    logic [PW-1:0] d;
    int unsigned idx = 0, frames = 0, beats = 0, cyc = 0;
    load_mem(1'b0);
    mode_req = '0;
    do_reset();
    while (beats < 2 * N + 4 && cyc < 2 * N + 40) begin
      cycle(1'b1, 1'b0, xf, d, s, e);
      cyc++;
      if (beats != 0) begin
        n_checks++;
        if (xf !== 1'b1) $display("FAIL steady_no_bubble got xfer=%b want 1 at beat %0d", xf, beats);
        else n_pass++;
      end
      if (xf) begin
        n_checks++;
        if ({d, s, e} !== {mem[idx], idx == 0, idx == N - 1})
          $display("FAIL steady_beat idx=%0d got d=%h sop=%b eop=%b want d=%h sop=%b eop=%b",
                   idx, d, s, e, mem[idx], idx == 0, idx == N - 1);
        else n_pass++;
        beats++;
        if (idx == N - 1) begin
          idx = 0;
          frames++;
          n_checks++;
          if (frame_count !== 16'(frames)) $display("FAIL steady_frame_count got %0d want %0d", frame_count, frames);
          else n_pass++;
        end else idx++;
      end
    end
    n_checks++;
    if (beats != 2 * N + 4) $display("FAIL steady_budget got %0d beats want %0d", beats, 2 * N + 4);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic xf, s, e, rdy, prev_stall;
    logic [PW-1:0] d;
    logic [PW+1:0] prev_beat;
    int unsigned idx = 0, frames = 0, beats = 0, cyc = 0, lead;
    load_mem(1'b1);
    do_reset();
    prev_stall = 1'b0;
    prev_beat  = '0;
    while (beats < 3 * N && cyc < 24 * N) begin
      if (prev_stall) begin
        n_checks++;
        if (src_valid !== 1'b1 || {src_data, src_sop, src_eop} !== prev_beat)
          $display("FAIL stall_hold got v=%b beat=%h want v=1 beat=%h", src_valid, {src_data, src_sop, src_eop}, prev_beat);
        else n_pass++;
      end
      rdy = ($urandom_range(0, 1) == 1);
      prev_stall = src_valid & ~rdy;
      prev_beat  = {src_data, src_sop, src_eop};
      cycle(rdy, 1'b0, xf, d, s, e);
      cyc++;
      if (xf) begin
        n_checks++;
        if ({d, s, e} !== {PW'(idx), idx == 0, idx == N - 1})
          $display("FAIL bp_beat idx=%0d got d=%h sop=%b eop=%b want d=%h sop=%b eop=%b",
                   idx, d, s, e, PW'(idx), idx == 0, idx == N - 1);
        else n_pass++;
        beats++;
        if (idx == N - 1) begin
          idx = 0;
          frames++;
        end else idx++;
      end
      lead = (32'(rd_addr) + N - idx) % N;
      n_checks++;
      if (lead > 2) $display("FAIL bp_read_lead got %0d want <=2 (addr=%0d next=%0d)", lead, rd_addr, idx);
      else n_pass++;
    end
    n_checks++;
    if (beats != 3 * N || frame_count !== 16'(frames))
      $display("FAIL bp_totals got beats=%0d fc=%0d want beats=%0d fc=%0d", beats, frame_count, 3 * N, frames);
    else n_pass++;
  endtask

  task automatic test_mode_latch();
    logic xf, s, e, rdy;
    logic [PW-1:0] d;
    logic [MW-1:0] am;
    logic [MW-1:0] modes [4];
    int unsigned idx = 0, frame = 0, beats = 0, cyc = 0;
    modes = '{3'd2, 3'd0, 3'd5, 3'd3};
    mode_req = modes[0];
    load_mem(1'b0);
    do_reset();
    while (beats < 3 * N && cyc < 16 * N) begin
      rdy = ($urandom_range(0, 3) != 0);
      if (idx == N / 2 && frame < 3) mode_req = modes[frame + 1];
      am = active_mode;
      cycle(rdy, 1'b0, xf, d, s, e);
      cyc++;
      if (xf) begin
        n_checks++;
        if (am !== modes[frame])
          $display("FAIL mode_latch frame=%0d idx=%0d got %0d want %0d", frame, idx, am, modes[frame]);
        else n_pass++;
        beats++;
        if (idx == N - 1) begin
          idx = 0;
          frame++;
        end else idx++;
      end
    end
    n_checks++;
    if (beats != 3 * N) $display("FAIL mode_budget got %0d beats want %0d", beats, 3 * N);
    else n_pass++;
  endtask

  task automatic test_restart();
    logic xf, s, e, rdy, rs;
    logic [PW-1:0] d, exp_d;
    int unsigned idx = 0, frame = 0, beats = 0, cyc = 0, r_idx = 0;
    bit pulsed1 = 0, pulsed2 = 0, zero_seen = 0;
    load_mem(1'b0);
    do_reset();
    while (beats < 2 * N && cyc < 16 * N) begin
      rdy = ($urandom_range(0, 9) < 6);
      rs  = 1'b0;
      if (frame == 0 && !pulsed1 && idx == 40) begin
        rs = 1'b1;
        pulsed1 = 1;
        r_idx = idx;
      end else if (frame == 0 && pulsed1 && !pulsed2 && idx >= 50) begin
        rs = 1'b1;
        pulsed2 = 1;
      end
      cycle(rdy, rs, xf, d, s, e);
      cyc++;
      if (xf) begin
        // Up to two already-fetched pixels may still be real; everything after is zero.
        exp_d = mem[idx];
        if (frame == 0 && pulsed1 && idx >= r_idx)
          if (zero_seen || idx >= r_idx + 2 || d !== mem[idx]) exp_d = '0;
        n_checks++;
        if ({d, s, e} !== {exp_d, idx == 0, idx == N - 1})
          $display("FAIL restart_beat frame=%0d idx=%0d got d=%h sop=%b eop=%b want d=%h sop=%b eop=%b",
                   frame, idx, d, s, e, exp_d, idx == 0, idx == N - 1);
        else n_pass++;
        if (frame == 0 && pulsed1 && d === '0) zero_seen = 1;
        beats++;
        if (idx == N - 1) begin
          idx = 0;
          frame++;
          n_checks++;
          if (frame_count !== 16'(frame)) $display("FAIL restart_frame_count got %0d want %0d", frame_count, frame);
          else n_pass++;
        end else idx++;
      end
    end
    restart = 1'b0;
    n_checks++;
    if (beats != 2 * N || !zero_seen || !pulsed2)
      $display("FAIL restart_totals got beats=%0d zeros=%0d pulses=%0d want beats=%0d zeros=1 pulses=1",
               beats, zero_seen, pulsed2, 2 * N);
    else n_pass++;
  endtask

  task automatic test_restart_eop();
    logic xf, s, e, rdy, rs;
    logic [PW-1:0] d;
    int unsigned idx = 0, frame = 0, beats = 0, cyc = 0;
    bit pulsed = 0;
    load_mem(1'b0);
    do_reset();
    while (beats < 2 * N && cyc < 16 * N) begin
      rdy = ($urandom_range(0, 9) < 7);
      rs  = 1'b0;
      if (!pulsed && frame == 0 && src_valid === 1'b1 && src_eop === 1'b1 && rdy) begin
        rs = 1'b1;
        pulsed = 1;
      end
      cycle(rdy, rs, xf, d, s, e);
      cyc++;
      if (xf) begin
        n_checks++;
        if ({d, s, e} !== {mem[idx], idx == 0, idx == N - 1})
          $display("FAIL restart_eop_beat frame=%0d idx=%0d got d=%h sop=%b eop=%b want d=%h sop=%b eop=%b",
                   frame, idx, d, s, e, mem[idx], idx == 0, idx == N - 1);
        else n_pass++;
        beats++;
        if (idx == N - 1) begin
          idx = 0;
          frame++;
          n_checks++;
          if (frame_count !== 16'(frame)) $display("FAIL restart_eop_frame_count got %0d want %0d", frame_count, frame);
          else n_pass++;
        end else idx++;
      end
    end
    restart = 1'b0;
    n_checks++;
    if (beats != 2 * N || !pulsed)
      $display("FAIL restart_eop_totals got beats=%0d pulsed=%0d want beats=%0d pulsed=1", beats, pulsed, 2 * N);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic xf, s, e;
    logic [PW-1:0] d;
    int unsigned idx = 0, beats = 0, cyc = 0;
    load_mem(1'b0);
    do_reset();
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, xf, d, s, e);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, xf, d, s, e);
    n_checks++;
    if (src_valid !== 1'b1 || rd_addr === '0) $display("FAIL stalled_before_reset got v=%b addr=%0d want v=1 addr!=0", src_valid, rd_addr);
    else n_pass++;
    #3 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({rd_addr, src_valid, src_sop, src_eop, src_data, active_mode, frame_count} !== '0)
      $display("FAIL async_reset_outputs got addr=%h v=%b sop=%b eop=%b d=%h mode=%h fc=%h want all zero",
               rd_addr, src_valid, src_sop, src_eop, src_data, active_mode, frame_count);
    else n_pass++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    while (beats < 20 && cyc < 60) begin
      cycle(1'b1, 1'b0, xf, d, s, e);
      cyc++;
      if (xf) begin
        n_checks++;
        if ({d, s, e} !== {mem[idx], idx == 0, 1'b0})
          $display("FAIL post_reset_beat idx=%0d got d=%h sop=%b eop=%b want d=%h sop=%b eop=0",
                   idx, d, s, e, mem[idx], idx == 0);
        else n_pass++;
        beats++;
        idx++;
      end
    end
    n_checks++;
    if (beats != 20 || frame_count !== 16'd0)
      $display("FAIL post_reset_totals got beats=%0d fc=%0d want beats=20 fc=0", beats, frame_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_steady();
    test_backpressure();
    test_mode_latch();
    test_restart();
    test_restart_eop();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end
endmodule
